// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline sequencing logic:
// FSM state encoding, register-zero constant, opcode constants and
// small decode/compare helpers used by the hazard controller.
package pipe_pkg;

   // Sequencing class of a cycle; also the visible FSM state encoding.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // Register $zero is hard-wired and can never carry a dependence.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Opcodes recognised by the main control unit.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   // Single place that decides whether an opcode reads the rt field.
   function automatic logic op_uses_rt(input logic [5:0] opcode);
      logic uses_s;
      case (opcode)
         OP_RTYPE: uses_s = 1'b1;
         OP_SW:    uses_s = 1'b1;
         OP_BEQ:   uses_s = 1'b1;
         OP_LW:    uses_s = 1'b0;
         default:  uses_s = 1'b0;
      endcase
      return uses_s;
   endfunction

   // True when an in-flight writer will update source register r.
   function automatic logic writer_hit(input logic       regwrite,
                                       input logic [4:0] dst,
                                       input logic [4:0] r);
      return regwrite & (dst != REG_ZERO) & (dst == r);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Pure comparator: does any older in-flight writer target this source
// register? The WB writer only counts when the register bank cannot
// forward a same-cycle write to the read port.
module hazard_cmp
   import pipe_pkg::*;
#(
   parameter int RF_WRITE_FIRST = 1
) (
   input  logic [4:0] src,
   input  logic [4:0] ex_dst,
   input  logic       ex_regwrite,
   input  logic [4:0] mem_dst,
   input  logic       mem_regwrite,
   input  logic [4:0] wb_dst,
   input  logic       wb_regwrite,
   output logic       match
);

   logic wb_hit_s;

   // Combine the EX, MEM and (optionally) WB writer comparisons.
   always_comb begin
      wb_hit_s = 1'b0;
      if (RF_WRITE_FIRST == 0) begin
         wb_hit_s = writer_hit(wb_regwrite, wb_dst, src);
      end else begin
         wb_hit_s = 1'b0;
      end
      match = writer_hit(ex_regwrite, ex_dst, src)
            | writer_hit(mem_regwrite, mem_dst, src)
            | wb_hit_s;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline without forwarding.
// Stalls ID on RAW hazards, flushes wrong-path work on a taken branch
// resolved in MEM, honours an external freeze, keeps saturating
// stall/flush statistics and a sticky watchdog for over-long stalls.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int RF_WRITE_FIRST = 1,
   parameter int MAX_STALL      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_dst,
   input  logic             ex_regwrite,
   input  logic [4:0]       mem_dst,
   input  logic             mem_regwrite,
   input  logic [4:0]       wb_dst,
   input  logic             wb_regwrite,
   input  logic             br_taken,
   input  logic             ext_hold,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err
);

   // Run length needs to represent 0..MAX_STALL+1.
   localparam int RL_W = $clog2(MAX_STALL + 2);
   localparam logic [RL_W-1:0]  RL_LIMIT = RL_W'(MAX_STALL);
   localparam logic [RL_W-1:0]  RL_TOP   = RL_W'(MAX_STALL + 1);
   localparam logic [RL_W-1:0]  RL_ONE   = RL_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic            rs_match_s;
   logic            rt_match_s;
   logic            raw_s;
   logic            stall_ev_s;
   state_t          next_state_s;
   state_t          state_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic [RL_W-1:0]  run_len_r;
   logic            err_r;

   hazard_cmp #(.RF_WRITE_FIRST(RF_WRITE_FIRST)) u_cmp_rs (
      .src          (id_rs),
      .ex_dst       (ex_dst),
      .ex_regwrite  (ex_regwrite),
      .mem_dst      (mem_dst),
      .mem_regwrite (mem_regwrite),
      .wb_dst       (wb_dst),
      .wb_regwrite  (wb_regwrite),
      .match        (rs_match_s)
   );

   hazard_cmp #(.RF_WRITE_FIRST(RF_WRITE_FIRST)) u_cmp_rt (
      .src          (id_rt),
      .ex_dst       (ex_dst),
      .ex_regwrite  (ex_regwrite),
      .mem_dst      (mem_dst),
      .mem_regwrite (mem_regwrite),
      .wb_dst       (wb_dst),
      .wb_regwrite  (wb_regwrite),
      .match        (rt_match_s)
   );

   // RAW hazard on the ID instruction, and whether this cycle is a counted stall.
   always_comb begin
      raw_s      = id_valid & (rs_match_s | (id_uses_rt & rt_match_s));
      stall_ev_s = raw_s & ~br_taken & ~ext_hold;
   end

   // Prioritised pipeline control: reset, branch flush, hold, stall, run.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (br_taken) begin
         pc_we       = 1'b1;
         ifid_we     = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (ext_hold) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
      end else if (raw_s) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         pc_we   = 1'b1;
         ifid_we = 1'b1;
      end
   end

   // Classify the current cycle; this becomes the visible state next cycle.
   always_comb begin
      next_state_s = ST_RUN;
      if (br_taken) begin
         next_state_s = ST_FLUSH;
      end else if (ext_hold) begin
         next_state_s = ST_HOLD;
      end else if (raw_s) begin
         next_state_s = ST_STALL;
      end else begin
         next_state_s = ST_RUN;
      end
   end

   // State register recording the class of the previous cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Saturating count of stall cycles that actually held the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Saturating count of taken-branch flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt_r <= {CNT_W{1'b0}};
      end else if (br_taken && (flush_cnt_r != CNT_MAX)) begin
         flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
         flush_cnt_r <= flush_cnt_r;
      end
   end

   // Watchdog: track consecutive stalls and latch err when the run gets too long.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_len_r <= {RL_W{1'b0}};
         err_r     <= 1'b0;
      end else if (stall_ev_s) begin
         if (run_len_r >= RL_LIMIT) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
         if (run_len_r != RL_TOP) begin
            run_len_r <= run_len_r + RL_ONE;
         end else begin
            run_len_r <= run_len_r;
         end
      end else begin
         run_len_r <= {RL_W{1'b0}};
         err_r     <= err_r;
      end
   end

   assign state     = state_r;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
   assign err       = err_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share stimulus:
// dut (write-first register bank, 16-bit counters) and dz (WB writer
// stalls, 2-bit counters so saturation is reachable quickly).
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid, id_uses_rt, ex_regwrite, mem_regwrite, wb_regwrite;
   logic        br_taken, ext_hold;
   logic [4:0]  id_rs, id_rt, ex_dst, mem_dst, wb_dst;

   logic        pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, err;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        z_pc_we, z_ifid_we, z_ifid_flush, z_idex_bubble, z_exmem_flush, z_err;
   logic [1:0]  z_state;
   logic [1:0]  z_stall_cnt, z_flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(16), .RF_WRITE_FIRST(1), .MAX_STALL(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
      .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .wb_dst(wb_dst),
      .wb_regwrite(wb_regwrite), .br_taken(br_taken), .ext_hold(ext_hold),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
   );

   pipe_hazard_ctrl #(.CNT_W(2), .RF_WRITE_FIRST(0), .MAX_STALL(3)) dz (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
      .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .wb_dst(wb_dst),
      .wb_regwrite(wb_regwrite), .br_taken(br_taken), .ext_hold(ext_hold),
      .pc_we(z_pc_we), .ifid_we(z_ifid_we), .ifid_flush(z_ifid_flush),
      .idex_bubble(z_idex_bubble), .exmem_flush(z_exmem_flush), .state(z_state),
      .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt), .err(z_err)
   );

   task automatic idle();
      id_valid = 1'b0; id_uses_rt = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
      ex_dst = 5'd0; ex_regwrite = 1'b0; mem_dst = 5'd0; mem_regwrite = 1'b0;
      wb_dst = 5'd0; wb_regwrite = 1'b0; br_taken = 1'b0; ext_hold = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
      n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
      n_vec++; if ({pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush} !== 5'b00111) begin n_err++; $display("FAIL rst_ctrl: got %b want 00111", {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush}); end
   endtask

   task automatic test_raw_rs();
      apply_reset();
      // lw $t1 in EX, add reading $t1 in ID
      id_valid = 1'b1; id_rs = 5'd9; id_rt = 5'd10; id_uses_rt = 1'b1;
      ex_regwrite = 1'b1; ex_dst = 5'd9;
      #1;
      n_vec++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== 4'b0010) begin n_err++; $display("FAIL rs_ex_ctrl: got %b want 0010", {pc_we, ifid_we, idex_bubble, ifid_flush}); end
      tick();
      n_vec++; if (state !== 2'd1 || stall_cnt !== 16'd1) begin n_err++; $display("FAIL rs_ex_seq: got st=%0d cnt=%0d want st=1 cnt=1", state, stall_cnt); end
      // writer moves to MEM, bubble in EX
      ex_regwrite = 1'b0; ex_dst = 5'd0; mem_regwrite = 1'b1; mem_dst = 5'd9;
      #1;
      n_vec++; if ({pc_we, idex_bubble} !== 2'b01) begin n_err++; $display("FAIL rs_mem_ctrl: got %b want 01", {pc_we, idex_bubble}); end
      tick();
      n_vec++; if (state !== 2'd1 || stall_cnt !== 16'd2) begin n_err++; $display("FAIL rs_mem_seq: got st=%0d cnt=%0d want st=1 cnt=2", state, stall_cnt); end
      // writer in WB: write-first bank resolves it, the other still stalls
      mem_regwrite = 1'b0; mem_dst = 5'd0; wb_regwrite = 1'b1; wb_dst = 5'd9;
      #1;
      n_vec++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) begin n_err++; $display("FAIL rs_wb_ctrl: got %b want 110", {pc_we, ifid_we, idex_bubble}); end
      n_vec++; if ({z_pc_we, z_idex_bubble} !== 2'b01) begin n_err++; $display("FAIL rs_wb_ctrl_rf0: got %b want 01", {z_pc_we, z_idex_bubble}); end
      tick();
      n_vec++; if (state !== 2'd0 || stall_cnt !== 16'd2) begin n_err++; $display("FAIL rs_wb_seq: got st=%0d cnt=%0d want st=0 cnt=2", state, stall_cnt); end
      n_vec++; if (z_state !== 2'd1 || z_stall_cnt !== 2'd3 || z_err !== 1'b0) begin n_err++; $display("FAIL rf0_3stall: got st=%0d cnt=%0d err=%b want 1/3/0", z_state, z_stall_cnt, z_err); end
      // fourth forced matching cycle trips the watchdog; 2-bit counter saturates
      tick();
      n_vec++; if (z_err !== 1'b1 || z_stall_cnt !== 2'd3) begin n_err++; $display("FAIL rf0_wdog: got err=%b cnt=%0d want 1/3", z_err, z_stall_cnt); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rf1_no_err: got %b want 0", err); end
      idle();
      tick();
      tick();
      n_vec++; if (z_state !== 2'd0 || z_err !== 1'b1) begin n_err++; $display("FAIL rf0_err_sticky: got st=%0d err=%b want 0/1", z_state, z_err); end
   endtask

   task automatic test_branch();
      apply_reset();
      id_valid = 1'b1; id_rs = 5'd9; ex_regwrite = 1'b1; ex_dst = 5'd9;
      br_taken = 1'b1; ext_hold = 1'b1;
      #1;
      n_vec++; if ({pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush} !== 5'b11111) begin n_err++; $display("FAIL br_ctrl: got %b want 11111", {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush}); end
      tick();
      n_vec++; if (state !== 2'd2 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL br_seq: got st=%0d fl=%0d st_cnt=%0d want 2/1/0", state, flush_cnt, stall_cnt); end
      idle();
      tick();
      n_vec++; if (state !== 2'd0 || flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_after: got st=%0d fl=%0d want 0/1", state, flush_cnt); end
   endtask

   task automatic test_hold();
      apply_reset();
      id_valid = 1'b1; id_rs = 5'd9; ex_regwrite = 1'b1; ex_dst = 5'd9;
      tick();
      tick();
      ext_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++; if ({pc_we, ifid_we, idex_bubble, ifid_flush, exmem_flush} !== 5'b00000) begin n_err++; $display("FAIL hold_ctrl%0d: got %b want 00000", i, {pc_we, ifid_we, idex_bubble, ifid_flush, exmem_flush}); end
         tick();
         n_vec++; if (state !== 2'd3 || stall_cnt !== 16'd2) begin n_err++; $display("FAIL hold_seq%0d: got st=%0d cnt=%0d want 3/2", i, state, stall_cnt); end
      end
      ext_hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++; if ({pc_we, idex_bubble} !== 2'b01) begin n_err++; $display("FAIL resume_ctrl%0d: got %b want 01", i, {pc_we, idex_bubble}); end
         tick();
         n_vec++; if (state !== 2'd1 || stall_cnt !== 16'(3 + i) || err !== 1'b0) begin n_err++; $display("FAIL resume_seq%0d: got st=%0d cnt=%0d err=%b want 1/%0d/0", i, state, stall_cnt, err, 3 + i); end
      end
      tick();
      n_vec++; if (err !== 1'b1 || stall_cnt !== 16'd6) begin n_err++; $display("FAIL resume_wdog: got err=%b cnt=%0d want 1/6", err, stall_cnt); end
      idle();
   endtask

   task automatic test_rt();
      apply_reset();
      id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
      mem_regwrite = 1'b1; mem_dst = 5'd5;
      #1;
      n_vec++; if ({pc_we, idex_bubble} !== 2'b10) begin n_err++; $display("FAIL rt_unused: got %b want 10", {pc_we, idex_bubble}); end
      id_uses_rt = 1'b1;
      #1;
      n_vec++; if ({pc_we, ifid_we, idex_bubble} !== 3'b001) begin n_err++; $display("FAIL rt_used: got %b want 001", {pc_we, ifid_we, idex_bubble}); end
      id_valid = 1'b0;
      #1;
      n_vec++; if ({pc_we, idex_bubble} !== 2'b10) begin n_err++; $display("FAIL rt_invalid: got %b want 10", {pc_we, idex_bubble}); end
      id_valid = 1'b1; mem_regwrite = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
      ex_regwrite = 1'b1; ex_dst = 5'd0; wb_regwrite = 1'b1; wb_dst = 5'd0;
      #1;
      n_vec++; if ({pc_we, idex_bubble} !== 2'b10 || {z_pc_we, z_idex_bubble} !== 2'b10) begin n_err++; $display("FAIL r0_nohaz: got %b/%b want 10/10", {pc_we, idex_bubble}, {z_pc_we, z_idex_bubble}); end
      idle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      id_valid = 1'b1; id_rs = 5'd9; ex_regwrite = 1'b1; ex_dst = 5'd9;
      repeat (7) tick();
      n_vec++; if (state !== 2'd1 || stall_cnt !== 16'd7 || flush_cnt !== 16'd1 || err !== 1'b1) begin n_err++; $display("FAIL pre_rst: got st=%0d sc=%0d fc=%0d err=%b want 1/7/1/1", state, stall_cnt, flush_cnt, err); end
      #2;
      rst = 1'b1;
      #1;
      n_vec++; if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL async_rst: got st=%0d sc=%0d fc=%0d err=%b want 0/0/0/0", state, stall_cnt, flush_cnt, err); end
      n_vec++; if ({pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush} !== 5'b00111) begin n_err++; $display("FAIL async_rst_ctrl: got %b want 00111", {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush}); end
      n_vec++; if (z_err !== 1'b0 || z_state !== 2'd0) begin n_err++; $display("FAIL async_rst_rf0: got err=%b st=%0d want 0/0", z_err, z_state); end
      tick();
      n_vec++; if (state !== 2'd0 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_held: got st=%0d sc=%0d want 0/0", state, stall_cnt); end
      idle();
      #2;
      rst = 1'b0;
      tick();
      n_vec++; if (state !== 2'd0 || stall_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL post_rst: got st=%0d sc=%0d err=%b want 0/0/0", state, stall_cnt, err); end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      test_reset();
      #2;
      rst = 1'b0;
      tick();
      test_raw_rs();
      test_branch();
      test_hold();
      test_rt();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined datapath (IF, ID, EX, MEM, WB); the datapath has no forwarding and resolves branches in MEM.
- Detects RAW hazards between the instruction in ID and older in-flight writers. Holds PC and IF/ID and injects an ID/EX bubble until the hazard clears.
- Flushes the three wrong-path instructions when a branch is taken in MEM.
- Honours an external hold and keeps stall/flush statistics plus a sticky watchdog error.

Parameters:
- CNT_W, 16, width of the stall and flush statistic counters (saturating).
- RF_WRITE_FIRST, 1. 1: the register bank writes in the first half-cycle, so a WB-stage writer is no hazard. 0: the WB-stage writer also stalls ID.
- MAX_STALL, 3, longest legal consecutive STALL run; exceeding it sets err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  IF/ID holds a real instruction (0 after flush or reset).
- id_rs  in  5  IF/ID instr[25:21].
- id_rt  in  5  IF/ID instr[20:16].
- id_uses_rt  in  1  decoded instruction reads rt (R-type, beq, sw).
- ex_dst  in  5  destination after the EX RegDst mux.
- ex_regwrite  in  1  ID/EX RegWrite.
- mem_dst  in  5  EX/MEM destination register.
- mem_regwrite  in  1  EX/MEM RegWrite.
- wb_dst  in  5  MEM/WB destination register.
- wb_regwrite  in  1  MEM/WB RegWrite.
- br_taken  in  1  Branch AND zero, valid in MEM (the PCSrc term).
- ext_hold  in  1  freeze request (e.g. memory not ready).
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  load a NOP/invalid into IF/ID at the next edge.
- idex_bubble  out  1  zero all ID/EX control bits at the next edge.
- exmem_flush  out  1  zero EX/MEM Branch/MemWrite/RegWrite at the next edge.
- state  out  2  current FSM state: RUN=0, STALL=1, FLUSH=2, HOLD=3.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total taken-branch flushes, saturating.
- err  out  1  sticky watchdog error.

Behaviour:
- Hazard term, combinational: src(r) = regwrite & (dst != 0) & (dst == r), evaluated for the EX and MEM writers, and for WB only when RF_WRITE_FIRST=0.
- raw = id_valid & (src(id_rs) | (id_uses_rt & src(id_rt))).
- Register 0 never causes a hazard.
- Control outputs are combinational from the current inputs, in strict priority order:
  - br_taken: pc_we=1 (the target is loaded), ifid_flush=1, idex_bubble=1, exmem_flush=1, ifid_we=1. raw and ext_hold are ignored this cycle.
  - else ext_hold: pc_we=0, ifid_we=0, all flush/bubble outputs 0. The whole pipe is frozen; the owner gates the other buffers with ext_hold.
  - else raw: pc_we=0, ifid_we=0, idex_bubble=1.
  - else: pc_we=1, ifid_we=1, all flush/bubble outputs 0.
- FSM, registered on the rising edge of clk:
  - next state = FLUSH if br_taken; else HOLD if ext_hold; else STALL if raw; else RUN.
  - The state register shows the class of the previous cycle, which the bench uses to check sequencing.
- Statistic counters, updated on the rising edge of clk:
  - stall_cnt += 1 in each cycle where raw=1 and neither br_taken nor ext_hold is asserted.
  - flush_cnt += 1 in each cycle where br_taken=1.
  - Both saturate at all-ones; no wrap.
- Watchdog:
  - run_len counts consecutive stall cycles; it is cleared by any non-stall cycle, including HOLD.
  - err is set when run_len would reach MAX_STALL+1.
  - err is cleared only by rst.
- Simultaneous events:
  - br_taken together with raw: the flush wins, and the stall is not counted (the younger instruction is squashed).
  - ext_hold together with raw: HOLD wins; run_len is cleared and no stall is counted.
- Reset (asynchronous, at any time including mid-stall):
  - state=RUN, stall_cnt=0, flush_cnt=0, run_len=0, err=0.
  - While rst=1, the combinational outputs are forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, so that bubbles fill the pipe.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_RUN, ST_STALL, ST_FLUSH, ST_HOLD.
  - REG_ZERO=5'd0.
  - the opcode constants already used by control (R-type, lw, sw, beq), so that id_uses_rt decode lives in one place.
- One sub-module, hazard_cmp: a pure comparator taking one source register plus the three writer (dst, regwrite) pairs and RF_WRITE_FIRST, returning match. It is instantiated twice (rs, rt).
- The FSM and counters stay in the top module.

Test Plan:
- lw into $t1 at EX (ex_regwrite=1, ex_dst=9); ID has add with rs=9, id_valid=1 -> stall sequence:
  - pc_we=0, idex_bubble=1 for 2 cycles while the writer moves EX then MEM (RF_WRITE_FIRST=1).
  - Third cycle: RUN. stall_cnt=2, state reads STALL, STALL, RUN.
- Same scenario with RF_WRITE_FIRST=0 -> 3 stall cycles, stall_cnt=3, err stays 0. Add a fourth forced matching cycle -> err=1 and remains 1 until rst.
- br_taken=1 in the same cycle as a raw match -> exmem_flush=idex_bubble=ifid_flush=1, pc_we=1; next state FLUSH; flush_cnt=1; stall_cnt unchanged.
- ext_hold=1 for 4 cycles during a raw match -> pc_we=ifid_we=0, idex_bubble=0, state HOLD, stall_cnt unchanged. After release, the stall resumes with run_len restarting at 1.
- rt hazard checks:
  - id_rt=5 matching mem_dst=5 with id_uses_rt=0 -> no stall.
  - id_uses_rt=1 -> stall.
  - ex_dst=0 with ex_regwrite=1 -> never stalls.
- rst asserted asynchronously mid-STALL with stall_cnt=7 -> immediately state=RUN, counters=0, err=0, and all flush/bubble outputs=1 while rst is high.
